// File: rtl/switch_allocator.sv
// Switch-allocation stage: per-output round-robin arbitration with packet lock.
// grant_o is combinational so input buffers can pop in the SA cycle.
// sel_o/valid_o are registered and steer the crossbar in the following ST cycle.
module switch_allocator #(
   parameter  int INPUT_NUM  = 5,
   parameter  int OUTPUT_NUM = 5,
   localparam int SEL_SIZE   = $clog2(INPUT_NUM),
   localparam int PORT_SIZE  = $clog2(OUTPUT_NUM)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [INPUT_NUM-1:0]                req_i,
   input  logic [INPUT_NUM-1:0][PORT_SIZE-1:0] out_port_i,
   input  logic [INPUT_NUM-1:0]                tail_i,
   input  logic [OUTPUT_NUM-1:0]               ready_i,
   output logic [INPUT_NUM-1:0]                grant_o,
   output logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0] sel_o,
   output logic [OUTPUT_NUM-1:0]               valid_o
);

   // One extra bit so ptr + offset never overflows before the modulo fold.
   localparam int CNT_W = SEL_SIZE + 1;

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e                                state_q [OUTPUT_NUM];
   state_e                                state_d [OUTPUT_NUM];
   logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]   ptr_q, ptr_d;
   logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]   owner_q, owner_d;
   logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0]  req_mat;
   logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0]  grant_mat;
   logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]   win_sel;

   // Decode each input's requested port into a per-output request vector; ids >= OUTPUT_NUM match nothing.
   always_comb begin
      req_mat = '0;
      for (int j = 0; j < OUTPUT_NUM; j++) begin
         for (int i = 0; i < INPUT_NUM; i++) begin
            req_mat[j][i] = req_i[i] && (out_port_i[i] == PORT_SIZE'(j));
         end
      end
   end

   // Per-output arbitration: round-robin from ptr when idle, owner-only while a packet holds the lock.
   always_comb begin : arbitrate
      logic [CNT_W-1:0]    idx;
      logic [SEL_SIZE-1:0] pick;
      logic                found;
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      grant_mat = '0;
      win_sel   = '0;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      for (int j = 0; j < OUTPUT_NUM; j++) begin
         state_d[j] = state_q[j];
      end
      for (int j = 0; j < OUTPUT_NUM; j++) begin
         found = 1'b0;
         pick  = '0;
         idx   = '0;
         if (ready_i[j]) begin
            if (state_q[j] == IDLE) begin
               for (int k = 0; k < INPUT_NUM; k++) begin
                  idx = {1'b0, ptr_q[j]} + CNT_W'(k);
                  if (idx >= CNT_W'(INPUT_NUM)) begin
                     idx = idx - CNT_W'(INPUT_NUM);
                  end
                  if (!found && req_mat[j][idx[SEL_SIZE-1:0]]) begin
                     found = 1'b1;
                     pick  = idx[SEL_SIZE-1:0];
                  end
               end
            end else if (req_mat[j][owner_q[j]]) begin
               found = 1'b1;
               pick  = owner_q[j];
            end
         end
         if (found) begin
            grant_mat[j][pick] = 1'b1;
            win_sel[j]         = pick;
            if (state_q[j] == IDLE) begin
               ptr_d[j] = (pick == SEL_SIZE'(INPUT_NUM - 1)) ? '0 : pick + 1'b1;
            end
            if (tail_i[pick]) begin
               state_d[j] = IDLE;
            end else begin
               state_d[j] = LOCKED;
               owner_d[j] = pick;
            end
         end
      end
   end

   // Fold per-output grants back to inputs; each input targets one port so at most one bit per input is set.
   always_comb begin
      grant_o = '0;
      if (rst) begin
         for (int j = 0; j < OUTPUT_NUM; j++) begin
            grant_o = grant_o | grant_mat[j];
         end
      end
   end

   // Arbitration state: lock FSM, owner and round-robin pointer per output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: all state here is a handful of flops, so every bit is reset; a dropped lock cannot leave a stale owner.
         for (int j = 0; j < OUTPUT_NUM; j++) begin
            state_q[j] <= IDLE;
         end
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge combinational values.
         for (int j = 0; j < OUTPUT_NUM; j++) begin
            state_q[j] <= state_d[j];
         end
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

   // ST-stage pipeline register: winner id and valid per output; select holds when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_o   <= '0;
         valid_o <= '0;
      end else begin
         for (int j = 0; j < OUTPUT_NUM; j++) begin
            valid_o[j] <= |grant_mat[j];
            if (|grant_mat[j]) begin
               sel_o[j] <= win_sel[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the allocation rules.
module tb_switch_allocator;

   localparam int INN  = 5;
   localparam int OUTN = 5;

   logic            clk;
   logic            rst;
   logic [4:0]      req;
   logic [4:0][2:0] out_port;
   logic [4:0]      tail;
   logic [4:0]      ready;
   logic [4:0]      grant;
   logic [4:0][2:0] sel;
   logic [4:0]      valid;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int         m_ptr   [OUTN];
   bit         m_lock  [OUTN];
   int         m_owner [OUTN];
   int         m_sel   [OUTN];
   bit         m_valid [OUTN];
   bit         m_got   [OUTN];
   int         m_win   [OUTN];
   logic [4:0] m_grant;

   switch_allocator #(.INPUT_NUM(INN), .OUTPUT_NUM(OUTN)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req),
      .out_port_i (out_port),
      .tail_i     (tail),
      .ready_i    (ready),
      .grant_o    (grant),
      .sel_o      (sel),
      .valid_o    (valid)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int j = 0; j < OUTN; j++) begin
         m_ptr[j] = 0; m_lock[j] = 0; m_owner[j] = 0;
         m_sel[j] = 0; m_valid[j] = 0; m_got[j] = 0; m_win[j] = 0;
      end
      m_grant = '0;
   endfunction

   // Winner per output: owner only when locked, else the requester closest after ptr in circular order.
   function automatic void model_eval();
      int reqs[$];
      int bestd;
      int d;
      m_grant = '0;
      for (int j = 0; j < OUTN; j++) begin
         m_got[j] = 0;
         reqs.delete();
         for (int i = 0; i < INN; i++) begin
            if (req[i] && int'(out_port[i]) == j) reqs.push_back(i);
         end
         if (ready[j] && reqs.size() > 0) begin
            if (m_lock[j]) begin
               foreach (reqs[k]) if (reqs[k] == m_owner[j]) m_got[j] = 1;
               if (m_got[j]) m_win[j] = m_owner[j];
            end else begin
               bestd = INN;
               foreach (reqs[k]) begin
                  d = (reqs[k] - m_ptr[j] + INN) % INN;
                  if (d < bestd) begin
                     bestd    = d;
                     m_win[j] = reqs[k];
                  end
               end
               m_got[j] = 1;
            end
            if (m_got[j]) m_grant[m_win[j]] = 1'b1;
         end
      end
   endfunction

   function automatic void model_commit();
      for (int j = 0; j < OUTN; j++) begin
         if (m_got[j]) begin
            m_valid[j] = 1;
            m_sel[j]   = m_win[j];
            if (!m_lock[j]) m_ptr[j] = (m_win[j] + 1) % INN;
            if (tail[m_win[j]]) begin
               m_lock[j] = 0;
            end else begin
               m_lock[j]  = 1;
               m_owner[j] = m_win[j];
            end
         end else begin
            m_valid[j] = 0;
         end
      end
   endfunction

   // One clock edge; model advances with the DUT, outputs settle 1 time unit after the edge.
   task automatic tick();
      model_eval();
      @(posedge clk);
      if (rst) model_commit();
      #1;
   endtask

   task automatic drive(input logic [4:0] rq, input logic [4:0] tl, input logic [4:0] rd,
                        input int p0, input int p1, input int p2, input int p3, input int p4);
      req = rq; tail = tl; ready = rd;
      out_port[0] = 3'(p0); out_port[1] = 3'(p1); out_port[2] = 3'(p2);
      out_port[3] = 3'(p3); out_port[4] = 3'(p4);
   endtask

   task automatic test_reset();
      #2;
      total++; if (valid !== 5'b0) begin bad++; $display("FAIL reset_valid: got %b want 00000", valid); end
      total++; if (sel !== '0) begin bad++; $display("FAIL reset_sel: got %h want 0", sel); end
      total++; if (grant !== 5'b0) begin bad++; $display("FAIL reset_grant: got %b want 00000", grant); end
      tick();
      rst = 1'b1;
      // Input 1 opens a packet on port 1, then reset hits mid-packet.
      drive(5'b00010, 5'b00000, 5'b11111, 0, 1, 0, 0, 0);
      #1;
      total++; if (grant !== 5'b00010) begin bad++; $display("FAIL pre_reset_grant: got %b want 00010", grant); end
      tick();
      total++; if (valid !== 5'b00010 || sel[1] !== 3'd1) begin
         bad++; $display("FAIL pre_reset_st: got valid=%b sel1=%0d want 00010/1", valid, sel[1]); end
      #1 rst = 1'b0;
      #1;
      total++; if (valid !== 5'b0 || sel !== '0 || grant !== 5'b0) begin
         bad++; $display("FAIL async_reset: got valid=%b sel=%h grant=%b want all 0", valid, sel, grant); end
      model_reset();
      tick();
      rst = 1'b1;
      drive(5'b01001, 5'b11111, 5'b11111, 0, 0, 0, 0, 0);
      #1;
      total++; if (grant !== 5'b00001) begin bad++; $display("FAIL post_reset_first: got %b want 00001", grant); end
      tick();
      total++; if (valid !== 5'b00001 || sel[0] !== 3'd0) begin
         bad++; $display("FAIL post_reset_st: got valid=%b sel0=%0d want 00001/0", valid, sel[0]); end
   endtask

   task automatic test_round_robin();
      int seq[3] = '{0, 2, 4};
      drive(5'b10101, 5'b11111, 5'b11111, 1, 0, 1, 0, 1);
      for (int c = 0; c < 6; c++) begin
         #1;
         total++; if (grant !== 5'(1 << seq[c % 3])) begin
            bad++; $display("FAIL rr_grant[%0d]: got %b want input %0d", c, grant, seq[c % 3]); end
         tick();
         total++; if (valid !== 5'b00010 || sel[1] !== 3'(seq[c % 3])) begin
            bad++; $display("FAIL rr_sel[%0d]: got valid=%b sel1=%0d want 00010/%0d", c, valid, sel[1], seq[c % 3]); end
      end
   endtask

   task automatic test_packet_lock();
      drive(5'b01000, 5'b00000, 5'b11111, 0, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         if (c >= 1) drive(5'b01010, (c == 3) ? 5'b01010 : 5'b00010, 5'b11111, 0, 0, 0, 0, 0);
         #1;
         total++; if (grant !== ((c < 4) ? 5'b01000 : 5'b00010)) begin
            bad++; $display("FAIL lock_grant[%0d]: got %b want %b", c, grant, (c < 4) ? 5'b01000 : 5'b00010); end
         tick();
         total++; if (valid !== 5'b00001 || sel[0] !== ((c < 4) ? 3'd3 : 3'd1)) begin
            bad++; $display("FAIL lock_sel[%0d]: got valid=%b sel0=%0d", c, valid, sel[0]); end
      end
   endtask

   task automatic test_back_pressure();
      drive(5'b10000, 5'b00000, 5'b11111, 0, 0, 0, 0, 2);
      #1;
      total++; if (grant !== 5'b10000) begin bad++; $display("FAIL bp_head: got %b want 10000", grant); end
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(5'b10001, 5'b00001, 5'b11011, 2, 0, 0, 0, 2);
         #1;
         total++; if (grant !== 5'b0) begin bad++; $display("FAIL bp_stall_grant[%0d]: got %b want 00000", c, grant); end
         tick();
         total++; if (valid !== 5'b0) begin bad++; $display("FAIL bp_stall_valid[%0d]: got %b want 00000", c, valid); end
      end
      drive(5'b10001, 5'b10001, 5'b11111, 2, 0, 0, 0, 2);
      #1;
      total++; if (grant !== 5'b10000) begin bad++; $display("FAIL bp_resume: got %b want 10000", grant); end
      tick();
      total++; if (valid !== 5'b00100 || sel[2] !== 3'd4) begin
         bad++; $display("FAIL bp_resume_st: got valid=%b sel2=%0d want 00100/4", valid, sel[2]); end
      drive(5'b00001, 5'b00001, 5'b11111, 2, 0, 0, 0, 0);
      #1;
      total++; if (grant !== 5'b00001) begin bad++; $display("FAIL bp_after: got %b want 00001", grant); end
      tick();
   endtask

   task automatic test_parallel();
      drive(5'b00111, 5'b11111, 5'b11111, 2, 3, 4, 0, 0);
      #1;
      total++; if (grant !== 5'b00111) begin bad++; $display("FAIL par_grant: got %b want 00111", grant); end
      tick();
      total++; if (valid !== 5'b11100 || sel[2] !== 3'd0 || sel[3] !== 3'd1 || sel[4] !== 3'd2) begin
         bad++; $display("FAIL par_st: got valid=%b sel2=%0d sel3=%0d sel4=%0d want 11100/0/1/2",
                         valid, sel[2], sel[3], sel[4]); end
   endtask

   task automatic test_wrap_invalid();
      drive(5'b01000, 5'b11111, 5'b11111, 0, 0, 0, 4, 0);
      #1;
      total++; if (grant !== 5'b01000) begin bad++; $display("FAIL wrap_setup: got %b want 01000", grant); end
      tick();
      drive(5'b10001, 5'b11111, 5'b11111, 4, 0, 0, 0, 4);
      #1;
      total++; if (grant !== 5'b10000) begin bad++; $display("FAIL wrap_ptr4: got %b want 10000", grant); end
      tick();
      total++; if (sel[4] !== 3'd4) begin bad++; $display("FAIL wrap_sel: got %0d want 4", sel[4]); end
      #1;
      total++; if (grant !== 5'b00001) begin bad++; $display("FAIL wrap_ptr0: got %b want 00001", grant); end
      tick();
      drive(5'b00110, 5'b11111, 5'b11111, 0, 7, 5, 0, 0);
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (grant !== 5'b0) begin bad++; $display("FAIL invalid_grant[%0d]: got %b want 00000", c, grant); end
         tick();
         total++; if (valid !== 5'b0) begin bad++; $display("FAIL invalid_valid[%0d]: got %b want 00000", c, valid); end
      end
   endtask

   task automatic test_random();
      logic [4:0]      exp_v;
      logic [4:0][2:0] exp_s;
      for (int n = 0; n < 400; n++) begin
         req  = 5'($urandom);
         tail = 5'($urandom);
         for (int j = 0; j < OUTN; j++) ready[j] = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < INN; i++) out_port[i] = 3'($urandom_range(0, 5));
         #1;
         model_eval();
         total++; if (grant !== m_grant) begin
            bad++; $display("FAIL rand_grant[%0d]: got %b want %b", n, grant, m_grant); end
         tick();
         for (int j = 0; j < OUTN; j++) begin
            exp_v[j] = m_valid[j];
            exp_s[j] = 3'(m_sel[j]);
         end
         total++; if (valid !== exp_v) begin
            bad++; $display("FAIL rand_valid[%0d]: got %b want %b", n, valid, exp_v); end
         total++; if (sel !== exp_s) begin
            bad++; $display("FAIL rand_sel[%0d]: got %h want %h", n, sel, exp_s); end
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
      model_reset();
      test_reset();
      test_round_robin();
      test_packet_lock();
      test_back_pressure();
      test_parallel();
      test_wrap_invalid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
